// File: rtl/addsub_arbiter.sv
// Purpose: round-robin arbiter sharing one N-bit adder/subtractor between two requesters.
// Latency: grant pulse in the cycle after the winning request edge; result valid one edge after that.
// Backpressure: result held until ack; no new request is accepted while busy (EXEC or RESP).
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req*/add_n*/x*/y*     per-requester request, op select (0 add, 1 sub) and operands
//   gnt0, gnt1            one-cycle grant pulse, operands captured
//   busy                  FSM not in IDLE
//   valid, id, s,         registered result, owner, carry out (sub: 1 = no borrow)
//   c_out, overflow       and signed overflow
//   ack                   consumer accepts the result (used only in RESP)

module adder_subtractor #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         add_n,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow
);
  logic [N-1:0] y_eff;
  logic [N:0]   sum;

  // Subtraction as x + ~y + 1: invert y and feed add_n in as carry-in.
  assign y_eff    = y ^ {N{add_n}};
  assign sum      = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, add_n};
  assign s        = sum[N-1:0];
  assign c_out    = sum[N];
  assign overflow = (x[N-1] & y_eff[N-1] & ~sum[N-1]) |
                    (~x[N-1] & ~y_eff[N-1] & sum[N-1]);
endmodule

module addsub_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         add_n0,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] y0,
  input  logic         req1,
  input  logic         add_n1,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         valid,
  output logic         id,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow,
  input  logic         ack
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_q;
  logic         take;
  logic         winner;
  logic [N-1:0] op_x_q, op_y_q;
  logic         op_add_n_q;
  logic [N-1:0] alu_s;
  logic         alu_c, alu_ov;

  adder_subtractor #(.N(N)) u_alu (
    .x        (op_x_q),
    .y        (op_y_q),
    .add_n    (op_add_n_q),
    .s        (alu_s),
    .c_out    (alu_c),
    .overflow (alu_ov)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          take = 1'b1;
          // On a tie the requester that did not win last time goes first.
          winner  = (req0 && req1) ? ~last_q : req1;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q     <= 1'b1;
      op_x_q     <= '0;
      op_y_q     <= '0;
      op_add_n_q <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      valid      <= 1'b0;
      id         <= 1'b0;
      s          <= '0;
      c_out      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      if (take) begin
        op_x_q     <= winner ? x1 : x0;
        op_y_q     <= winner ? y1 : y0;
        op_add_n_q <= winner ? add_n1 : add_n0;
        gnt0       <= ~winner;
        gnt1       <= winner;
        last_q     <= winner;
        id         <= winner;
      end
      if (state_q == EXEC) begin
        s        <= alu_s;
        c_out    <= alu_c;
        overflow <= alu_ov;
        valid    <= 1'b1;
      end
      // Result registers keep their value after ack; only valid drops.
      if (state_q == RESP && ack) valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Purpose: randomized and directed bench for addsub_arbiter against a transaction-timeline model.
// Latency: model expects grant one edge after a sampled request and result one edge after grant.
// Backpressure: ack is randomized; the model holds the result until ack is sampled in the response phase.

module tb_addsub_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0 = 1'b0, add_n0 = 1'b0, req1 = 1'b0, add_n1 = 1'b0, ack = 1'b0;
  logic [N-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic         gnt0, gnt1, busy, valid, id, c_out, overflow;
  logic [N-1:0] s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  addsub_arbiter #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .add_n0(add_n0), .x0(x0), .y0(y0),
    .req1(req1), .add_n1(add_n1), .x1(x1), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid), .id(id),
    .s(s), .c_out(c_out), .overflow(overflow), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic on plain integers: {overflow, carry, sum}.
  function automatic logic [N+1:0] ref_op(input bit sub, input int x, input int y);
    int m, h, sx, sy, full, r;
    bit c;
    logic [N+1:0] res;
    m  = 1 << N;
    h  = m / 2;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    if (sub) begin
      full = x - y;
      r    = sx - sy;
      c    = (x >= y);
    end else begin
      full = x + y;
      r    = sx + sy;
      c    = (full >= m);
    end
    full = ((full % m) + m) % m;
    res[N-1:0] = full[N-1:0];
    res[N]     = c;
    res[N+1]   = (r > h - 1) || (r < -h);
    return res;
  endfunction

  // Transaction timeline model: an operation is granted at edge g,
  // its result appears at edge g+1 and is retired on a later ack edge.
  bit           m_inflight = 0;
  int           m_gcyc = 0;
  bit           m_last = 1;
  bit           e_gnt0 = 0, e_gnt1 = 0, e_valid = 0, e_id = 0;
  logic [N+1:0] e_res = '0, p_res = '0;

  always @(posedge clk) begin
    bit w;
    cyc++;
    if (!reset_n) begin
      m_inflight = 0; m_last = 1;
      e_gnt0 = 0; e_gnt1 = 0; e_valid = 0; e_id = 0; e_res = '0;
    end else begin
      e_gnt0 = 0; e_gnt1 = 0;
      if (!m_inflight) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? !m_last : req1;
          m_last = w; e_id = w; m_inflight = 1; m_gcyc = cyc;
          p_res = w ? ref_op(add_n1, int'(x1), int'(y1)) : ref_op(add_n0, int'(x0), int'(y0));
          if (w) e_gnt1 = 1; else e_gnt0 = 1;
        end
      end else if (cyc == m_gcyc + 1) begin
        e_valid = 1; e_res = p_res;
      end else if (ack) begin
        e_valid = 0; m_inflight = 0;
      end
    end
    #1;
    check_val("gnt0", 32'(gnt0), 32'(e_gnt0));
    check_val("gnt1", 32'(gnt1), 32'(e_gnt1));
    check_val("busy", 32'(busy), 32'(m_inflight));
    check_val("valid", 32'(valid), 32'(e_valid));
    check_val("id", 32'(id), 32'(e_id));
    check_val("s", 32'(s), 32'(e_res[N-1:0]));
    check_val("c_out", 32'(c_out), 32'(e_res[N]));
    check_val("overflow", 32'(overflow), 32'(e_res[N+1]));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(input bit who, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (who ? gnt1 : gnt0) begin ok = 1; break; end
    end
    check_val("gnt_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin ok = 1; break; end
    end
    check_val("valid_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_op(input bit who, input bit sub, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] exp_s, input bit exp_c, input bit exp_ov);
    bit ok;
    @(negedge clk);
    if (who) begin req1 = 1; add_n1 = sub; x1 = x; y1 = y; end
    else     begin req0 = 1; add_n0 = sub; x0 = x; y0 = y; end
    wait_gnt(who, ok);
    req0 = 0; req1 = 0;
    wait_valid(ok);
    check_val("dir_id", 32'(id), 32'(who));
    check_val("dir_s", 32'(s), 32'(exp_s));
    check_val("dir_c_out", 32'(c_out), 32'(exp_c));
    check_val("dir_overflow", 32'(overflow), 32'(exp_ov));
    ack = 1;
    @(negedge clk);
    ack = 0;
    check_val("dir_valid_after_ack", 32'(valid), 32'd0);
    check_val("dir_busy_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int gcyc[$];
    int gwho[$];

    @(negedge clk);
    check_val("reset_valid", 32'(valid), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_s", 32'(s), 32'd0);
    reset_n = 1;

    // Directed arithmetic vectors, including the one-cycle grant width.
    @(negedge clk);
    req0 = 1; add_n0 = 0; x0 = 4'd3; y0 = 4'd2;
    wait_gnt(0, ok);
    req0 = 0;
    @(negedge clk);
    check_val("gnt0_width", 32'(gnt0), 32'd0);
    check_val("first_valid", 32'(valid), 32'd1);
    check_val("first_s", 32'(s), 32'd5);
    check_val("first_id", 32'(id), 32'd0);
    ack = 1;
    @(negedge clk);
    ack = 0;
    check_val("first_busy_after_ack", 32'(busy), 32'd0);

    do_op(1, 1, 4'd3, 4'd5, 4'hE, 0, 0);
    do_op(0, 0, 4'd7, 4'd1, 4'h8, 0, 1);
    do_op(0, 1, 4'h8, 4'd1, 4'h7, 1, 1);
    do_op(1, 0, 4'hF, 4'd1, 4'h0, 1, 0);

    // Fairness: both request continuously, ack tied high.
    @(negedge clk);
    req0 = 1; add_n0 = 0; x0 = 4'd2; y0 = 4'd1;
    req1 = 1; add_n1 = 1; x1 = 4'd6; y1 = 4'd3;
    ack = 1;
    for (int i = 0; i < 40 && gcyc.size() < 6; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin gcyc.push_back(cyc); gwho.push_back(int'(gnt1)); end
    end
    check_val("fair_count", 32'(gcyc.size()), 32'd6);
    for (int i = 0; i < gcyc.size(); i++) begin
      check_val("fair_order", 32'(gwho[i]), 32'(i % 2));
      if (i > 0) check_val("fair_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
    ack = 0;

    // Ack withheld: result and id stable, no grant to a waiting requester.
    req0 = 1; add_n0 = 0; x0 = 4'd1; y0 = 4'd1;
    wait_gnt(0, ok);
    req0 = 0;
    wait_valid(ok);
    req1 = 1; add_n1 = 0; x1 = 4'd4; y1 = 4'd4;
    x0 = 4'd9; y0 = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(valid), 32'd1);
      check_val("hold_s", 32'(s), 32'd2);
      check_val("hold_id", 32'(id), 32'd0);
      check_val("hold_no_gnt1", 32'(gnt1), 32'd0);
    end
    ack = 1;
    @(negedge clk);
    ack = 0;
    check_val("post_ack_no_gnt1", 32'(gnt1), 32'd0);
    wait_gnt(1, ok);
    req1 = 0;
    wait_valid(ok);
    check_val("hold_next_s", 32'(s), 32'd8);
    ack = 1;
    @(negedge clk);
    ack = 0;

    // Reset during EXEC discards the operation.
    req0 = 1; add_n0 = 0; x0 = 4'd5; y0 = 4'd6;
    wait_gnt(0, ok);
    req0 = 0;
    reset_n = 0;
    @(negedge clk);
    check_val("rst_exec_valid", 32'(valid), 32'd0);
    check_val("rst_exec_busy", 32'(busy), 32'd0);
    check_val("rst_exec_s", 32'(s), 32'd0);
    reset_n = 1;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_no_valid", 32'(valid), 32'd0);
    end
    req0 = 1; req1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) break;
    end
    check_val("rst_tie_gnt0", 32'(gnt0), 32'd1);
    check_val("rst_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 0; req1 = 0;
    wait_valid(ok);
    ack = 1;
    @(negedge clk);
    ack = 0;

    // Randomized traffic with random ack and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 199) != 0);
      if (req0 && gnt0) begin
        if ($urandom_range(0, 1) == 1) begin
          add_n0 = 1'($urandom_range(0, 1)); x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15));
        end else req0 = 0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; add_n0 = 1'($urandom_range(0, 1)); x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15));
      end
      if (req1 && gnt1) begin
        if ($urandom_range(0, 1) == 1) begin
          add_n1 = 1'($urandom_range(0, 1)); x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15));
        end else req1 = 0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; add_n1 = 1'($urandom_range(0, 1)); x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15));
      end
      ack = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
